// File: rtl/riscv_hazard_unit.sv
// riscv_hazard_unit: hazard controller for the 3-stage core (F | D/E | M/WB).
// It handles:
//   - operand forwarding from M/WB into D/E;
//   - load-use stalls for a data memory with MEM_LAT-cycle read latency;
//   - wrong-path flushes after a taken branch or jump.
// Optional feature macro: HAZARD_PERF_CNT_EN adds saturating stall/flush
// cycle counters (stall_cnt_o, flush_cnt_o).
// state_o exposes the FSM state (RUN=0, LD_WAIT=1, FLUSH=2) for debug.
module riscv_hazard_unit #(
  parameter int REGW     = 5,
  parameter int MEM_LAT  = 1,
  parameter int BR_FLUSH = 1,
  parameter int CNTW     = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [REGW-1:0] rs1_d_i,
  input  logic [REGW-1:0] rs2_d_i,
  input  logic            rs1_used_i,
  input  logic            rs2_used_i,
  input  logic            valid_d_i,
  input  logic [REGW-1:0] rd_m_i,
  input  logic            reg_write_m_i,
  input  logic            load_m_i,
  input  logic            valid_m_i,
  input  logic            br_taken_i,
  output logic            forward_a_o,
  output logic            forward_b_o,
  output logic            stall_f_o,
  output logic            stall_d_o,
  output logic            stall_m_o,
  output logic            flush_d_o,
  output logic            ld_busy_o,
  output logic [1:0]      state_o
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNTW-1:0] stall_cnt_o,
  output logic [CNTW-1:0] flush_cnt_o
`endif
);

  localparam logic [1:0] S_RUN     = 2'd0;
  localparam logic [1:0] S_LD_WAIT = 2'd1;
  localparam logic [1:0] S_FLUSH   = 2'd2;

  // The load itself costs one stall cycle in RUN, so LD_WAIT counts the rest.
  localparam logic       LAT_EN = (MEM_LAT > 0);
  localparam logic [2:0] LAT_M1 = 3'((MEM_LAT > 0) ? MEM_LAT - 1 : 0);
  localparam logic [1:0] BF_M1  = 2'((BR_FLUSH > 1) ? BR_FLUSH - 1 : 0);

  logic [1:0] state, state_n;
  logic [2:0] cnt, cnt_n;
  logic [1:0] fcnt, fcnt_n;

  logic m_a, m_b, luh;
  logic fwd_a, fwd_b, stall, flush, br_ok;

  // Register-match terms; x0 never matches.
  always_comb begin
    m_a = valid_m_i && reg_write_m_i && (rd_m_i != '0) && rs1_used_i
          && valid_d_i && (rd_m_i == rs1_d_i);
    m_b = valid_m_i && reg_write_m_i && (rd_m_i != '0) && rs2_used_i
          && valid_d_i && (rd_m_i == rs2_d_i);
    luh = LAT_EN && load_m_i && (m_a || m_b);
  end

  // Next-state and Mealy control decode; stall always wins over flush.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    fcnt_n  = fcnt;
    fwd_a   = 1'b0;
    fwd_b   = 1'b0;
    stall   = 1'b0;
    flush   = 1'b0;
    br_ok   = 1'b0;
    case (state)
      S_LD_WAIT: begin
        if (cnt != 3'd0) begin
          stall = 1'b1;
          cnt_n = cnt - 3'd1;
        end else begin
          // Load data is now on data_wb.
          fwd_a   = m_a;
          fwd_b   = m_b;
          state_n = S_RUN;
          br_ok   = 1'b1;
        end
      end
      default: begin
        // RUN and FLUSH both keep checking hazards.
        if (luh) begin
          stall   = 1'b1;
          state_n = S_LD_WAIT;
          cnt_n   = LAT_M1;
          fcnt_n  = 2'd0;
        end else begin
          fwd_a = m_a;
          fwd_b = m_b;
          br_ok = 1'b1;
          if (state == S_FLUSH) begin
            flush  = 1'b1;
            fcnt_n = fcnt - 2'd1;
            if (fcnt <= 2'd1) state_n = S_RUN;
          end
        end
      end
    endcase
    // A branch is only trusted when its operands are not being stalled.
    if (br_ok && br_taken_i) begin
      flush = 1'b1;
      if (BR_FLUSH > 1) begin
        state_n = S_FLUSH;
        fcnt_n  = BF_M1;
      end else begin
        state_n = S_RUN;
        fcnt_n  = 2'd0;
      end
    end
  end

  // FSM and counters; reset aborts any wait or flush in progress.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= S_RUN;
      cnt   <= 3'd0;
      fcnt  <= 2'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      fcnt  <= fcnt_n;
    end
  end

  // Outputs are forced low while reset is held.
  always_comb begin
    forward_a_o = fwd_a && !rst_i;
    forward_b_o = fwd_b && !rst_i;
    stall_f_o   = stall && !rst_i;
    stall_d_o   = stall && !rst_i;
    stall_m_o   = stall && !rst_i;
    flush_d_o   = flush && !rst_i;
    ld_busy_o   = (state == S_LD_WAIT) && !rst_i;
    state_o     = state;
  end

`ifdef HAZARD_PERF_CNT_EN
  // Saturating hazard cycle counters.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (stall_f_o && (stall_cnt_o != '1)) stall_cnt_o <= stall_cnt_o + 1'b1;
      if (flush_d_o && (flush_cnt_o != '1)) flush_cnt_o <= flush_cnt_o + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_riscv_hazard_unit.sv
// Testbench for riscv_hazard_unit. Three instances share one input stream:
//   dut0: MEM_LAT=2, BR_FLUSH=2 (CNTW=4)
//   dut1: MEM_LAT=0, BR_FLUSH=1
//   dut2: MEM_LAT=3, BR_FLUSH=3
// Each instance is checked every cycle against a reference model built from
// the hazard rules. Directed cases cover forwarding, load-use stalls, x0,
// branch flushes and reset mid-wait. These are followed by random traffic.
// Define HAZARD_PERF_CNT_EN to also check the saturating counters.
module tb_riscv_hazard_unit;

  logic       clk;
  logic       rst;
  logic [4:0] rs1_d, rs2_d, rd_m;
  logic       rs1_used, rs2_used, valid_d, reg_write_m, load_m, valid_m, br_taken;

  // {fwd_a, fwd_b, stall_f, stall_d, stall_m, flush_d, ld_busy}
  logic [6:0] got  [3];
  logic [6:0] snap [3];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Model state, per instance: in a load wait, stall cycles left, flush cycles left.
  int lat_t [3] = '{2, 0, 3};
  int bf_t  [3] = '{2, 1, 3};
  bit waiting [3];
  int srem    [3];
  int frem    [3];
  int n_stall0 = 0;
  int n_flush0 = 0;

  // Clock generation
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int L = (g == 0) ? 2 : (g == 1) ? 0 : 3;
    localparam int B = (g == 0) ? 2 : (g == 1) ? 1 : 3;
    logic fa, fb, sf, sd, sm, fl, busy;
    logic [1:0] st;
`ifdef HAZARD_PERF_CNT_EN
    logic [3:0] stall_cnt, flush_cnt;
`endif
    riscv_hazard_unit #(.REGW(5), .MEM_LAT(L), .BR_FLUSH(B), .CNTW(4)) u_dut (
      .clk_i(clk), .rst_i(rst),
      .rs1_d_i(rs1_d), .rs2_d_i(rs2_d),
      .rs1_used_i(rs1_used), .rs2_used_i(rs2_used), .valid_d_i(valid_d),
      .rd_m_i(rd_m), .reg_write_m_i(reg_write_m), .load_m_i(load_m),
      .valid_m_i(valid_m), .br_taken_i(br_taken),
      .forward_a_o(fa), .forward_b_o(fb),
      .stall_f_o(sf), .stall_d_o(sd), .stall_m_o(sm),
      .flush_d_o(fl), .ld_busy_o(busy), .state_o(st)
`ifdef HAZARD_PERF_CNT_EN
      , .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
`endif
    );
    assign got[g] = {fa, fb, sf, sd, sm, fl, busy};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  // Reference model: one cycle of instance i with the current inputs.
  task automatic model_step(input int i, output logic [6:0] e);
    logic ma, mb, stl, fl, fa, fb, busy;
    ma = valid_m && reg_write_m && (rd_m != 0) && rs1_used && valid_d && (rd_m == rs1_d);
    mb = valid_m && reg_write_m && (rd_m != 0) && rs2_used && valid_d && (rd_m == rs2_d);
    fa = 0; fb = 0; stl = 0; fl = 0;
    busy = waiting[i];
    if (rst) begin
      waiting[i] = 0; srem[i] = 0; frem[i] = 0;
      if (i == 0) begin n_stall0 = 0; n_flush0 = 0; end
      e = '0;
      return;
    end
    if (waiting[i]) begin
      if (srem[i] > 0) begin
        stl = 1; srem[i]--;
      end else begin
        waiting[i] = 0; fa = ma; fb = mb;
      end
    end else if (load_m && (ma || mb) && lat_t[i] > 0) begin
      stl = 1; waiting[i] = 1; srem[i] = lat_t[i] - 1; frem[i] = 0;
    end else begin
      fa = ma; fb = mb;
    end
    if (!stl) begin
      if (br_taken) begin
        fl = 1; frem[i] = bf_t[i] - 1;
      end else if (frem[i] > 0) begin
        fl = 1; frem[i]--;
      end
    end
    if (i == 0 && stl) n_stall0++;
    if (i == 0 && fl)  n_flush0++;
    e = {fa, fb, stl, stl, stl, fl, busy};
  endtask

  // Inputs are already driven (just after a falling edge): check, then advance.
  task automatic step();
    logic [6:0] e;
    #1;
    for (int i = 0; i < 3; i++) begin
      snap[i] = got[i];
      model_step(i, e);
      check($sformatf("dut%0d_out", i), {25'd0, got[i]}, {25'd0, e});
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic drive(input logic [4:0] a, input logic [4:0] b, input logic ua,
                       input logic ub, input logic vd, input logic [4:0] rd,
                       input logic rw, input logic ld, input logic vm, input logic br);
    rs1_d = a; rs2_d = b; rs1_used = ua; rs2_used = ub; valid_d = vd;
    rd_m = rd; reg_write_m = rw; load_m = ld; valid_m = vm; br_taken = br;
  endtask

  task automatic idle(input int n);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    step();
    check("reset_out0", {25'd0, snap[0]}, 32'd0);
    rst = 1'b0;

    // add x5 in M, D reads rs1=x5
    drive(5, 3, 1, 0, 1, 5, 1, 0, 1, 0);
    step();
    check("fwd_a_alu", {25'd0, snap[0]}, {25'd0, 7'b1000000});

    // lw x7 in M, D reads rs2=x7: two stall cycles then forward on dut0
    drive(1, 7, 1, 1, 1, 7, 1, 1, 1, 0);
    step();
    check("lu_c1", {25'd0, snap[0]}, {25'd0, 7'b0011100});
    check("lu_lat0", {25'd0, snap[1]}, {25'd0, 7'b0100000});
    step();
    check("lu_c2", {25'd0, snap[0]}, {25'd0, 7'b0011101});
    step();
    check("lu_c3", {25'd0, snap[0]}, {25'd0, 7'b0100001});
    idle(4);

    // x0 destination: never forwards or stalls
    drive(0, 0, 1, 1, 1, 0, 1, 1, 1, 0);
    step();
    for (int i = 0; i < 3; i++) check($sformatf("x0_dut%0d", i), {25'd0, snap[i]}, 32'd0);
    idle(1);

    // branch pulse: dut0 flushes two cycles
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step();
    check("br_c1", {25'd0, snap[0]}, {25'd0, 7'b0000010});
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    check("br_c2", {25'd0, snap[0]}, {25'd0, 7'b0000010});
    step();
    check("br_c3", {25'd0, snap[0]}, 32'd0);
    idle(3);

    // branch during a load stall is held off until the exit cycle
    drive(2, 9, 0, 1, 1, 9, 1, 1, 1, 1);
    step();
    check("brst_c1", {25'd0, snap[0]}, {25'd0, 7'b0011100});
    step();
    check("brst_c2", {25'd0, snap[0]}, {25'd0, 7'b0011101});
    step();
    check("brst_c3", {25'd0, snap[0]}, {25'd0, 7'b0100011});
    idle(5);

    // reset in the middle of dut2's load wait
    drive(4, 0, 1, 0, 1, 4, 1, 1, 1, 0);
    step();
    step();
    rst = 1'b1;
    step();
    check("rst_mid_wait", {25'd0, snap[2]}, 32'd0);
    step();
    rst = 1'b0;
    idle(1);
    check("rst_release", {25'd0, snap[2]}, 32'd0);
    check("rst_state", {30'd0, g_dut[2].st}, 32'd0);

    // random traffic on a small register set so hazards are frequent
    for (int n = 0; n < 800; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 4) != 0), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 4) != 0), ($urandom_range(0, 5) == 0));
      step();
    end
    rst = 1'b0;

`ifdef HAZARD_PERF_CNT_EN
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    drive(3, 0, 1, 0, 1, 3, 1, 1, 1, 0);
    for (int k = 0; k < 30; k++) step();
    check("stall_cnt_sat", {28'd0, g_dut[0].stall_cnt},
          (n_stall0 > 15) ? 32'd15 : 32'(n_stall0));
    check("stall_cnt_ff", {28'd0, g_dut[0].stall_cnt}, 32'hF);
    check("flush_cnt", {28'd0, g_dut[0].flush_cnt},
          (n_flush0 > 15) ? 32'd15 : 32'(n_flush0));
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
